gpio_config_loader: RTL and testbench
=====================================

Name: gpio_config_loader

Overview:
- Consumer end of the per-pad GPIO defaults bus.
- Captures the 10-bit tie-cell default word after reset and holds the live pad configuration register.
- Also forms one link of the housekeeping serial configuration chain: shift in, load, pass through to the next pad.
- One instance sits beside each GPIO pad, between its defaults block and the pad cell.

Parameters:
- WIDTH, 10, configuration word width; must equal the defaults bus width.
- CNT_W, 4, width of the shift-count register; 2^CNT_W must exceed WIDTH.

Ports:
- clk  input  1  single block clock; serial shifting uses the enable below, not a second clock
- resetn  input  1  asynchronous active-low reset
- gpio_defaults  input  WIDTH  static default word from the tie-cell block
- defaults_reload  input  1  pulse; re-copies gpio_defaults into cfg
- serial_shift_en  input  1  one chain bit per cycle while high
- serial_data_in  input  1  chain data from the previous pad
- serial_load  input  1  pulse; transfers the shift register into cfg
- serial_data_out  output  1  chain data to the next pad; equals shreg[WIDTH-1]
- cfg  output  WIDTH  live configuration: [0] mgmt_ena, [1] oeb, [2] holdover, [3] inp_dis, [4] pullup, [5] pulldown, [6] schmitt, [7] slew, [9:8] drive
- cfg_valid  output  1  high once the defaults have been captured
- load_err  output  1  sticky short-load flag

Behaviour:
- Reset: asynchronous assert with resetn=0.
  - Values while in reset: cfg=10'h002 (oeb=1, everything else off), shreg=0, bit_cnt=0, cfg_valid=0, load_err=0, state=INIT.
- FSM states: INIT, DEFLT, RUN.
  - INIT -> DEFLT on the first clk edge after resetn rises.
  - DEFLT: on that edge cfg<=gpio_defaults and cfg_valid<=1. State goes to RUN.
  - cfg therefore shows the defaults 2 edges after resetn deasserts.
  - RUN is terminal until the next reset. All shift, load and reload inputs are ignored in INIT and DEFLT.
- Shift (RUN, serial_shift_en=1):
  - shreg<={shreg[WIDTH-2:0], serial_data_in}; MSB is sent first.
  - serial_data_out is combinational from shreg[WIDTH-1], so chain latency per pad is WIDTH shift cycles.
  - bit_cnt increments and saturates at 2^CNT_W-1; it does not wrap.
- Load (RUN, serial_load=1):
  - If bit_cnt>=WIDTH: cfg<=shreg, using the value before any same-cycle shift.
  - Otherwise cfg is unchanged and load_err<=1.
  - bit_cnt clears either way. If shift_en is high in the same cycle, bit_cnt becomes 1 instead of 0, and that cycle's shift still occurs.
- defaults_reload (RUN):
  - cfg<=gpio_defaults next edge.
  - Has priority over a simultaneous serial_load. The load is dropped, bit_cnt is not cleared, and load_err is not set.
  - shreg is unaffected.
- load_err clears only on reset.
- Reset mid-shift: all partial chain data is discarded, and the INIT/DEFLT sequence repeats.
- gpio_defaults is treated as quasi-static and is sampled only in DEFLT or on reload; no synchroniser is required.

Optional Feature:
- Macro: GPIO_CFG_READBACK_EN.
- With the macro defined:
  - Adds input serial_capture (1 bit).
  - A pulse in RUN does shreg<=cfg and bit_cnt<=0, so the live configuration can be shifted out along the chain.
  - Priority order: capture > shift. Capture together with load performs the load and ignores the capture.
- Without the macro: the port and its logic are absent, and shreg is written only by shifting.

Test Plan:
- gpio_defaults=10'h007; release reset -> cfg=10'h002 for the first edge, then cfg=10'h007 with cfg_valid=1 after the 2nd edge.
- Shift 10'h3A5 MSB first (10 enabled cycles), then pulse serial_load -> cfg=10'h3A5, load_err=0.
- Shift 20 bits (10'h155 followed by 10'h2AA) -> serial_data_out reproduces 10'h155 during cycles 11-20. After load, cfg=10'h2AA.
- Shift 5 bits, then load -> cfg unchanged, load_err=1 and it stays 1 through a later valid load of 10'h0F0, which sets cfg=10'h0F0.
- After cfg=10'h0F0, pulse defaults_reload and serial_load together with defaults 10'h007 -> cfg=10'h007. Assert resetn=0 mid-shift -> cfg=10'h002 immediately, then 10'h007 after 2 edges.
- (GPIO_CFG_READBACK_EN) With cfg=10'h3A5, pulse serial_capture then shift 10 cycles -> serial_data_out bits read 1,1,1,0,1,0,0,1,0,1.

Source files
------------

// File: rtl/gpio_config_loader.sv
// Per-pad GPIO configuration register: captures tie-cell defaults after reset and
// forms one link of the serial housekeeping chain. Optional readback via GPIO_CFG_READBACK_EN.
module gpio_config_loader #(
  parameter int WIDTH = 10,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [WIDTH-1:0] gpio_defaults,
  input  logic             defaults_reload,
  input  logic             serial_shift_en,
  input  logic             serial_data_in,
`ifdef GPIO_CFG_READBACK_EN
  input  logic             serial_capture,
`endif
  input  logic             serial_load,
  output logic             serial_data_out,
  output logic [WIDTH-1:0] cfg,
  output logic             cfg_valid,
  output logic             load_err
);

  typedef enum logic [1:0] {
    INIT  = 2'd0,
    DEFLT = 2'd1,
    RUN   = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] CFG_RESET = WIDTH'(2);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(WIDTH);

  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic [CNT_W-1:0] bit_cnt;
  logic             load_take;
  logic             capture_hit;

  // A reload wins over a simultaneous load, which is then dropped entirely.
  assign load_take = serial_load && !defaults_reload;

`ifdef GPIO_CFG_READBACK_EN
  assign capture_hit = serial_capture && !load_take;
`else
  assign capture_hit = 1'b0;
`endif

  assign serial_data_out = shreg[WIDTH-1];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= INIT;
      cfg       <= CFG_RESET;
      shreg     <= '0;
      bit_cnt   <= '0;
      cfg_valid <= 1'b0;
      load_err  <= 1'b0;
    end else begin
      case (state)
        INIT: state <= DEFLT;
        DEFLT: begin
          cfg       <= gpio_defaults;
          cfg_valid <= 1'b1;
          state     <= RUN;
        end
        RUN: begin
          if (capture_hit) begin
            shreg <= cfg;
          end else if (serial_shift_en) begin
            shreg <= {shreg[WIDTH-2:0], serial_data_in};
          end

          // Load always sees the shift register as it was before this edge.
          if (defaults_reload) begin
            cfg <= gpio_defaults;
          end else if (serial_load) begin
            if (bit_cnt >= CNT_FULL) begin
              cfg <= shreg;
            end else begin
              load_err <= 1'b1;
            end
          end

          if (load_take) begin
            bit_cnt <= serial_shift_en ? CNT_W'(1) : '0;
          end else if (capture_hit) begin
            bit_cnt <= '0;
          end else if (serial_shift_en && (bit_cnt != CNT_MAX)) begin
            bit_cnt <= bit_cnt + CNT_W'(1);
          end
        end
        default: state <= INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_gpio_config_loader.sv
// Directed self-checking bench for gpio_config_loader.
module tb_gpio_config_loader;

  logic       clk;
  logic       resetn;
  logic [9:0] gpio_defaults;
  logic       defaults_reload;
  logic       serial_shift_en;
  logic       serial_data_in;
  logic       serial_load;
  logic       serial_data_out;
  logic [9:0] cfg;
  logic       cfg_valid;
  logic       load_err;
`ifdef GPIO_CFG_READBACK_EN
  logic       serial_capture;
`endif

  int total = 0;
  int bad   = 0;

  gpio_config_loader #(.WIDTH(10), .CNT_W(4)) dut (
    .clk             (clk),
    .resetn          (resetn),
    .gpio_defaults   (gpio_defaults),
    .defaults_reload (defaults_reload),
    .serial_shift_en (serial_shift_en),
    .serial_data_in  (serial_data_in),
`ifdef GPIO_CFG_READBACK_EN
    .serial_capture  (serial_capture),
`endif
    .serial_load     (serial_load),
    .serial_data_out (serial_data_out),
    .cfg             (cfg),
    .cfg_valid       (cfg_valid),
    .load_err        (load_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Advance one clock and settle just after the active edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic shift_bits(input logic [9:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      serial_data_in  = v[i];
      serial_shift_en = 1'b1;
      tick();
    end
    serial_shift_en = 1'b0;
    serial_data_in  = 1'b0;
  endtask

  task automatic pulse_load();
    serial_load = 1'b1;
    tick();
    serial_load = 1'b0;
  endtask

  task automatic test_reset();
    resetn          = 1'b0;
    gpio_defaults   = 10'h007;
    defaults_reload = 1'b0;
    serial_shift_en = 1'b0;
    serial_data_in  = 1'b0;
    serial_load     = 1'b0;
`ifdef GPIO_CFG_READBACK_EN
    serial_capture  = 1'b0;
`endif
    tick();
    tick();
    total++; if (cfg !== 10'h002) begin bad++; $display("[TB] FAIL reset_cfg got=%h exp=002", cfg); end
    total++; if (cfg_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_valid got=%b exp=0", cfg_valid); end
    total++; if (load_err !== 1'b0) begin bad++; $display("[TB] FAIL reset_err got=%b exp=0", load_err); end
    total++; if (serial_data_out !== 1'b0) begin bad++; $display("[TB] FAIL reset_sdo got=%b exp=0", serial_data_out); end
    resetn = 1'b1;
    tick();
    total++; if (cfg !== 10'h002) begin bad++; $display("[TB] FAIL init_cfg got=%h exp=002", cfg); end
    total++; if (cfg_valid !== 1'b0) begin bad++; $display("[TB] FAIL init_valid got=%b exp=0", cfg_valid); end
    tick();
    total++; if (cfg !== 10'h007) begin bad++; $display("[TB] FAIL deflt_cfg got=%h exp=007", cfg); end
    total++; if (cfg_valid !== 1'b1) begin bad++; $display("[TB] FAIL deflt_valid got=%b exp=1", cfg_valid); end
  endtask

  task automatic test_shift_load();
    shift_bits(10'h3A5, 10);
    pulse_load();
    total++; if (cfg !== 10'h3A5) begin bad++; $display("[TB] FAIL load_cfg got=%h exp=3a5", cfg); end
    total++; if (load_err !== 1'b0) begin bad++; $display("[TB] FAIL load_err got=%b exp=0", load_err); end
  endtask

  // 20 shifts also drives the count past 15, so a wrapping counter fails the load.
  task automatic test_chain();
    logic [9:0] first;
    logic [9:0] second;
    first  = 10'h155;
    second = 10'h2AA;
    shift_bits(first, 10);
    for (int i = 9; i >= 0; i--) begin
      total++;
      if (serial_data_out !== first[i]) begin
        bad++;
        $display("[TB] FAIL chain_sdo bit%0d got=%b exp=%b", i, serial_data_out, first[i]);
      end
      serial_data_in  = second[i];
      serial_shift_en = 1'b1;
      tick();
    end
    serial_shift_en = 1'b0;
    pulse_load();
    total++; if (cfg !== 10'h2AA) begin bad++; $display("[TB] FAIL chain_cfg got=%h exp=2aa", cfg); end
    total++; if (load_err !== 1'b0) begin bad++; $display("[TB] FAIL chain_err got=%b exp=0", load_err); end
  endtask

  task automatic test_load_with_shift();
    shift_bits(10'h3C3, 10);
    serial_load     = 1'b1;
    serial_shift_en = 1'b1;
    serial_data_in  = 1'b1;
    tick();
    serial_load     = 1'b0;
    serial_shift_en = 1'b0;
    serial_data_in  = 1'b0;
    total++; if (cfg !== 10'h3C3) begin bad++; $display("[TB] FAIL ldsh_cfg got=%h exp=3c3", cfg); end
    shift_bits(10'h055, 9);
    pulse_load();
    total++; if (cfg !== 10'h255) begin bad++; $display("[TB] FAIL ldsh_cnt1 got=%h exp=255", cfg); end
    total++; if (load_err !== 1'b0) begin bad++; $display("[TB] FAIL ldsh_err got=%b exp=0", load_err); end
  endtask

  task automatic test_short_load();
    shift_bits(10'h015, 5);
    pulse_load();
    total++; if (cfg !== 10'h255) begin bad++; $display("[TB] FAIL short_cfg got=%h exp=255", cfg); end
    total++; if (load_err !== 1'b1) begin bad++; $display("[TB] FAIL short_err got=%b exp=1", load_err); end
    shift_bits(10'h0F0, 10);
    pulse_load();
    total++; if (cfg !== 10'h0F0) begin bad++; $display("[TB] FAIL after_short_cfg got=%h exp=0f0", cfg); end
    total++; if (load_err !== 1'b1) begin bad++; $display("[TB] FAIL sticky_err got=%b exp=1", load_err); end
  endtask

  task automatic test_reload_priority();
    gpio_defaults = 10'h007;
    shift_bits(10'h3FF, 10);
    defaults_reload = 1'b1;
    serial_load     = 1'b1;
    tick();
    defaults_reload = 1'b0;
    serial_load     = 1'b0;
    total++; if (cfg !== 10'h007) begin bad++; $display("[TB] FAIL reload_cfg got=%h exp=007", cfg); end
    pulse_load();
    total++; if (cfg !== 10'h3FF) begin bad++; $display("[TB] FAIL reload_keepcnt got=%h exp=3ff", cfg); end
  endtask

  task automatic test_reset_midshift();
    shift_bits(10'h3FF, 10);
    serial_shift_en = 1'b1;
    serial_data_in  = 1'b1;
    tick();
    tick();
    tick();
    resetn = 1'b0;
    #1;
    total++; if (cfg !== 10'h002) begin bad++; $display("[TB] FAIL mid_cfg got=%h exp=002", cfg); end
    total++; if (cfg_valid !== 1'b0) begin bad++; $display("[TB] FAIL mid_valid got=%b exp=0", cfg_valid); end
    total++; if (load_err !== 1'b0) begin bad++; $display("[TB] FAIL mid_err got=%b exp=0", load_err); end
    total++; if (serial_data_out !== 1'b0) begin bad++; $display("[TB] FAIL mid_sdo got=%b exp=0", serial_data_out); end
    serial_shift_en = 1'b0;
    serial_data_in  = 1'b0;
    #2;
    resetn = 1'b1;
    tick();
    total++; if (cfg !== 10'h002) begin bad++; $display("[TB] FAIL mid_init_cfg got=%h exp=002", cfg); end
    tick();
    total++; if (cfg !== 10'h007) begin bad++; $display("[TB] FAIL mid_deflt_cfg got=%h exp=007", cfg); end
    total++; if (cfg_valid !== 1'b1) begin bad++; $display("[TB] FAIL mid_deflt_valid got=%b exp=1", cfg_valid); end
    pulse_load();
    total++; if (cfg !== 10'h007) begin bad++; $display("[TB] FAIL mid_noshift_cfg got=%h exp=007", cfg); end
    total++; if (load_err !== 1'b1) begin bad++; $display("[TB] FAIL mid_noshift_err got=%b exp=1", load_err); end
  endtask

`ifdef GPIO_CFG_READBACK_EN
  task automatic test_readback();
    logic [9:0] exp_bits;
    exp_bits = 10'h3A5;
    shift_bits(10'h3A5, 10);
    pulse_load();
    shift_bits(10'h000, 10);
    serial_capture = 1'b1;
    tick();
    serial_capture = 1'b0;
    for (int i = 9; i >= 0; i--) begin
      total++;
      if (serial_data_out !== exp_bits[i]) begin
        bad++;
        $display("[TB] FAIL readback bit%0d got=%b exp=%b", i, serial_data_out, exp_bits[i]);
      end
      serial_data_in  = 1'b0;
      serial_shift_en = 1'b1;
      tick();
    end
    serial_shift_en = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_shift_load();
    test_chain();
    test_load_with_shift();
    test_short_load();
    test_reload_priority();
    test_reset_midshift();
`ifdef GPIO_CFG_READBACK_EN
    test_readback();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
